fetch_controller: RTL and testbench
===================================

// Module: fetch_controller
// PURPOSE
// - Sequences instruction fetch around the 16-bit program counter register.
// - Issues one-outstanding requests to instruction memory at the current PC, and drives the PC stall
//   so the PC advances only on an accepted request or a taken redirect.
// - Discards wrong-path responses after a redirect.
// - Holds the fetched instruction in a one-entry output slot for decode.
// PARAMETERS
// - ADDR_W    16     PC / imem address width
// - INSTR_W   32     instruction width
// - MAX_WAIT  8      cycles a request may stay outstanding before timeout_err_o (>=2)
// PORTS
// - clk            in   1        single clock, all state on posedge
// - rst            in   1        synchronous, active-high reset
// - pc_i           in   ADDR_W   current PC register value = next fetch address
// - redirect_i     in   1        branch/jal/jalr taken this cycle; PC loads target next cycle
// - pc_stall_o     out  1        1 = PC register holds; 0 = PC updates (pc+4 or redirect target)
// - imem_req_o     out  1        fetch request valid
// - imem_addr_o    out  ADDR_W   fetch address (= pc_i while imem_req_o)
// - imem_gnt_i     in   1        request accepted this cycle
// - imem_rvalid_i  in   1        response valid (no backpressure, in order, 1 per grant)
// - imem_rdata_i   in   INSTR_W  response data
// - if_valid_o     out  1        output slot holds an instruction
// - if_instr_o     out  INSTR_W  instruction in slot
// - if_pc_o        out  ADDR_W   PC of instruction in slot
// - id_ready_i     in   1        decode accepts slot (transfer = if_valid_o & id_ready_i)
// - timeout_err_o  out  1        sticky: outstanding request exceeded MAX_WAIT cycles
// - perf_fetch_o   out  16       delivered instruction count (see CONFIGURATION)
// - perf_drop_o    out  16       discarded response count (see CONFIGURATION)
// BEHAVIOUR
// - Reset: state=IDLE; if_valid_o=0; if_instr_o=0; if_pc_o=0; timeout_err_o=0; wait counter=0.
//   imem_req_o=0 and pc_stall_o=1 while rst.
// - States: IDLE -> REQ unconditionally one cycle after reset release.
// - REQ: imem_req_o = (!if_valid_o | id_ready_i) & !redirect_i; imem_addr_o=pc_i.
//   - fire (req & gnt) -> WAIT; capture pc_i into pc_q.
// - WAIT: on rvalid, load slot {imem_rdata_i, pc_q}, set if_valid_o -> REQ.
// - DROP: on rvalid, discard response (no slot write) -> REQ.
// - pc_stall_o = !(fire | redirect_i), combinational. PC moves +4 exactly once per fire.
// - Latency: gnt in cycle N, rvalid in N+k (k>=1) -> if_valid_o=1 in N+k+1.
//   Next request no earlier than N+k+1; max throughput 1 instr / 2 cycles.
// - Slot: cleared on transfer unless refilled same cycle. Requests only issue when the slot is empty or
//   draining, so a response never overwrites a held instruction.
// - Redirect (priority over all other events, any state):
//   - if_valid_o=0 next cycle (flush, even if id_ready_i).
//   - REQ -> REQ (no req issued that cycle).
//   - WAIT without rvalid -> DROP; WAIT with rvalid same cycle -> data discarded -> REQ.
//   - DROP -> DROP unless rvalid same cycle -> REQ.
// - Wait counter: cleared on fire; +1 per cycle in WAIT/DROP, saturating at MAX_WAIT.
//   Reaching MAX_WAIT sets timeout_err_o (sticky until rst); FSM keeps waiting.
// - Unexpected rvalid in IDLE/REQ: ignored, no state change.
// - Reset mid-transaction: returns to IDLE; any later stale rvalid is ignored (IDLE/REQ rule).
// CONFIGURATION
// - FETCH_CTRL_PERF_EN defined: perf_fetch_o +1 per transfer; perf_drop_o +1 per discarded response.
//   Both 16-bit, saturating at 16'hFFFF, zeroed by rst.
// - FETCH_CTRL_PERF_EN undefined: no counter flops; perf_fetch_o and perf_drop_o tied to 0.
// TESTING
// - Reset pc_i=0, gnt=1, rvalid 1 cycle after gnt, id_ready=1:
//   -> addrs 0,4,8 requested; if_pc_o 0,4,8; pc_stall_o low only on fire cycles.
// - gnt held low 3 cycles in REQ -> imem_req_o stays 1, pc_stall_o=1 for 3 cycles, addr stable.
// - id_ready=0 with slot full -> no new imem_req_o; if_instr_o stable; release ready -> request next cycle.
// - redirect_i in WAIT, rvalid 2 cycles later -> DROP, response discarded, if_valid_o stays 0, then REQ at
//   new pc_i. With FETCH_CTRL_PERF_EN: perf_drop_o=1.
// - redirect_i coincident with gnt -> pc_stall_o=0, no pc_q capture, next rvalid discarded.
// - MAX_WAIT=8, no rvalid after gnt -> timeout_err_o=1 after 8th wait cycle; stays 1 until rst.

Source files
------------

// File: rtl/fetch_controller.sv
// fetch_controller: instruction fetch sequencer around the PC register.
// Issues one outstanding imem request at pc_i, stalls the PC except on an
// accepted request or a taken redirect, discards wrong-path responses and
// holds the fetched instruction in a one-entry slot for decode.
// Optional feature macro: FETCH_CTRL_PERF_EN (transfer / drop counters).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   pc_i, redirect_i         current PC, redirect taken this cycle
//   pc_stall_o               1 = PC register holds (combinational)
//   imem_req_o/addr_o        fetch request and address (combinational)
//   imem_gnt_i/rvalid_i/rdata_i  memory grant and response
//   if_valid_o/instr_o/pc_o  output slot towards decode
//   id_ready_i               decode accepts the slot
//   timeout_err_o            sticky outstanding-request timeout
//   perf_fetch_o/drop_o      delivered / discarded counts (0 unless enabled)
module fetch_controller #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned INSTR_W  = 32,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  pc_i,
    input  logic               redirect_i,
    output logic               pc_stall_o,
    output logic               imem_req_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic               imem_gnt_i,
    input  logic               imem_rvalid_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic               if_valid_o,
    output logic [INSTR_W-1:0] if_instr_o,
    output logic [ADDR_W-1:0]  if_pc_o,
    input  logic               id_ready_i,
    output logic               timeout_err_o,
    output logic [15:0]        perf_fetch_o,
    output logic [15:0]        perf_drop_o
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DROP
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [ADDR_W-1:0]  pc_q;
    logic [CNT_W-1:0]   wcnt;
    logic               fire;
    logic               rsp_keep;
    logic               rsp_drop;
    logic               waiting;
    logic               xfer;

    assign imem_addr_o = pc_i;
    assign waiting     = (state == S_WAIT) || (state == S_DROP);
    assign xfer        = if_valid_o & id_ready_i;

    // Next state, request and response classification; redirect wins everywhere.
    always_comb begin
        state_n    = state;
        imem_req_o = 1'b0;
        fire       = 1'b0;
        rsp_keep   = 1'b0;
        rsp_drop   = 1'b0;
        case (state)
            S_IDLE: state_n = S_REQ;
            S_REQ: begin
                // Only request when the slot is free or draining this cycle.
                imem_req_o = (!if_valid_o || id_ready_i) && !redirect_i;
                fire       = imem_req_o && imem_gnt_i;
                if (fire) state_n = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid_i) begin
                    state_n  = S_REQ;
                    rsp_drop = redirect_i;
                    rsp_keep = !redirect_i;
                end else if (redirect_i) begin
                    state_n = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_rvalid_i) begin
                    state_n  = S_REQ;
                    rsp_drop = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (rst) begin
            imem_req_o = 1'b0;
            fire       = 1'b0;
            rsp_keep   = 1'b0;
            rsp_drop   = 1'b0;
        end
    end

    assign pc_stall_o = rst || !(fire || redirect_i);

    // State, slot, wait counter and sticky timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            pc_q          <= '0;
            if_valid_o    <= 1'b0;
            if_instr_o    <= '0;
            if_pc_o       <= '0;
            wcnt          <= '0;
            timeout_err_o <= 1'b0;
        end else begin
            state <= state_n;
            if (fire) pc_q <= pc_i;

            if (redirect_i) begin
                if_valid_o <= 1'b0;
            end else if (rsp_keep) begin
                if_valid_o <= 1'b1;
                if_instr_o <= imem_rdata_i;
                if_pc_o    <= pc_q;
            end else if (xfer) begin
                if_valid_o <= 1'b0;
            end

            if (fire) begin
                wcnt <= '0;
            end else if (waiting && (wcnt != CNT_W'(MAX_WAIT))) begin
                wcnt <= wcnt + 1'b1;
            end

            if (waiting && (wcnt == CNT_W'(MAX_WAIT - 1))) timeout_err_o <= 1'b1;
        end
    end

`ifdef FETCH_CTRL_PERF_EN
    logic [15:0] perf_fetch_q;
    logic [15:0] perf_drop_q;

    // Saturating delivered / discarded counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_q <= '0;
            perf_drop_q  <= '0;
        end else begin
            if (xfer && (perf_fetch_q != 16'hFFFF)) perf_fetch_q <= perf_fetch_q + 16'd1;
            if (rsp_drop && (perf_drop_q != 16'hFFFF)) perf_drop_q <= perf_drop_q + 16'd1;
        end
    end

    assign perf_fetch_o = perf_fetch_q;
    assign perf_drop_o  = perf_drop_q;
`else
    assign perf_fetch_o = 16'd0;
    assign perf_drop_o  = 16'd0;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed scenarios plus randomized traffic checked
// against a transaction-level model (PC register, memory responder, slot).
module tb_fetch_controller;

    localparam int unsigned ADDR_W   = 16;
    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned MAX_WAIT = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [ADDR_W-1:0]  pc_i = '0;
    logic               redirect_i = 1'b0;
    logic               pc_stall_o;
    logic               imem_req_o;
    logic [ADDR_W-1:0]  imem_addr_o;
    logic               imem_gnt_i = 1'b0;
    logic               imem_rvalid_i = 1'b0;
    logic [INSTR_W-1:0] imem_rdata_i = '0;
    logic               if_valid_o;
    logic [INSTR_W-1:0] if_instr_o;
    logic [ADDR_W-1:0]  if_pc_o;
    logic               id_ready_i = 1'b0;
    logic               timeout_err_o;
    logic [15:0]        perf_fetch_o;
    logic [15:0]        perf_drop_o;

    always #5 clk = ~clk;

    fetch_controller #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst), .pc_i(pc_i), .redirect_i(redirect_i), .pc_stall_o(pc_stall_o),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i), .if_valid_o(if_valid_o),
        .if_instr_o(if_instr_o), .if_pc_o(if_pc_o), .id_ready_i(id_ready_i),
        .timeout_err_o(timeout_err_o), .perf_fetch_o(perf_fetch_o), .perf_drop_o(perf_drop_o)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: PC register, one-deep memory responder, decode slot.
    logic [15:0] m_pc = '0;
    logic [15:0] m_tgt = '0;
    bit          m_started = 0;
    bit          m_pend = 0;
    bit          m_squash = 0;
    logic [15:0] m_raddr = '0;
    int          m_cd = 0;
    bit          m_slot_v = 0;
    logic [15:0] m_slot_pc = '0;
    logic [31:0] m_slot_instr = '0;
    int          m_wcnt = 0;
    bit          m_err = 0;
    int          m_pf = 0;
    int          m_pd = 0;
    bit          m_exp_req = 0;
    int          k_next = 1;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {a ^ 16'hA5C3, ~a};
    endfunction

    function automatic logic [15:0] exp_pf();
`ifdef FETCH_CTRL_PERF_EN
        return 16'(m_pf);
`else
        return 16'd0;
`endif
    endfunction

    function automatic logic [15:0] exp_pd();
`ifdef FETCH_CTRL_PERF_EN
        return 16'(m_pd);
`else
        return 16'd0;
`endif
    endfunction

    // Apply one cycle of inputs; the responder answers k cycles after a grant.
    task automatic drive(input bit g, input bit rd, input bit rdy, input logic [15:0] tgt, input bit stray);
        bit rv;
        rv            = m_pend && (m_cd == 1);
        imem_gnt_i    = g;
        redirect_i    = rd;
        id_ready_i    = rdy;
        m_tgt         = tgt;
        pc_i          = m_pc;
        imem_rvalid_i = rv || stray;
        imem_rdata_i  = rv ? mem_word(m_raddr) : 32'hDEAD_BEEF;
        m_exp_req     = !rst && m_started && !m_pend && (!m_slot_v || rdy) && !rd;
        #2;
    endtask

    // Clock edge: advance the reference model from the inputs just applied.
    task automatic tick();
        bit fire, xfer, rv, drop, good;
        @(posedge clk);
        if (rst) begin
            m_started = 0; m_pend = 0; m_squash = 0; m_slot_v = 0;
            m_slot_pc = '0; m_slot_instr = '0; m_wcnt = 0; m_err = 0; m_pf = 0; m_pd = 0;
        end else begin
            fire = m_exp_req && imem_gnt_i;
            xfer = m_slot_v && id_ready_i;
            rv   = m_pend && (m_cd == 1);
            drop = rv && (m_squash || redirect_i);
            good = rv && !drop;
            if (xfer) m_pf++;
            if (drop) m_pd++;
            if (m_pend && !fire) begin
                if (m_wcnt < MAX_WAIT) m_wcnt++;
                if (m_wcnt >= MAX_WAIT) m_err = 1;
            end
            if (redirect_i) m_slot_v = 0;
            else if (good) begin
                m_slot_v = 1; m_slot_pc = m_raddr; m_slot_instr = mem_word(m_raddr);
            end else if (xfer) m_slot_v = 0;
            if (fire) begin
                m_pend = 1; m_squash = 0; m_raddr = m_pc; m_cd = k_next; m_wcnt = 0;
            end else if (rv) begin
                m_pend = 0;
            end else if (m_pend) begin
                if (redirect_i) m_squash = 1;
                m_cd--;
            end
            if (fire) m_pc = m_pc + 16'd4;
            else if (redirect_i) m_pc = m_tgt;
            m_started = 1;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 0, 0, 16'h0, 0);
        tick();
        drive(1, 0, 1, 16'h0, 0);
        vectors++;
        if (imem_req_o !== 1'b0 || pc_stall_o !== 1'b1) begin
            miscompares++; $display("FAIL reset_req_stall: req=%b stall=%b want req=0 stall=1", imem_req_o, pc_stall_o);
        end
        vectors++;
        if (if_valid_o !== 1'b0 || if_pc_o !== 16'h0 || if_instr_o !== 32'h0) begin
            miscompares++; $display("FAIL reset_slot: v=%b pc=%h instr=%h want 0", if_valid_o, if_pc_o, if_instr_o);
        end
        vectors++;
        if (timeout_err_o !== 1'b0 || perf_fetch_o !== 16'h0 || perf_drop_o !== 16'h0) begin
            miscompares++; $display("FAIL reset_err_perf: err=%b pf=%h pd=%h want 0", timeout_err_o, perf_fetch_o, perf_drop_o);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_in_order();
        logic [15:0] a;
        k_next = 1;
        for (int c = 0; c < 9; c++) begin
            drive(1, 0, 1, 16'h0, 0);
            vectors++;
            if (imem_req_o !== 1'(c % 2) || pc_stall_o !== 1'(!(c % 2))) begin
                miscompares++; $display("FAIL in_order_req c=%0d: req=%b stall=%b want req=%0d", c, imem_req_o, pc_stall_o, c % 2);
            end
            a = 16'(4 * ((c - 1) / 2));
            vectors++;
            if ((c % 2 == 1) && imem_addr_o !== a) begin
                miscompares++; $display("FAIL in_order_addr c=%0d: addr=%h want %h", c, imem_addr_o, a);
            end
            a = 16'(4 * ((c - 3) / 2));
            vectors++;
            if (if_valid_o !== 1'(c >= 3 && c % 2 == 1) ||
                (c >= 3 && c % 2 == 1 && (if_pc_o !== a || if_instr_o !== mem_word(a)))) begin
                miscompares++; $display("FAIL in_order_slot c=%0d: v=%b pc=%h instr=%h want pc=%h", c, if_valid_o, if_pc_o, if_instr_o, a);
            end
            tick();
        end
    endtask

    task automatic test_gnt_stall();
        logic [15:0] a0;
        a0 = m_pc;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 16'h0, 0);
            vectors++;
            if (imem_req_o !== 1'b1 || pc_stall_o !== 1'b1 || imem_addr_o !== a0) begin
                miscompares++; $display("FAIL gnt_low %0d: req=%b stall=%b addr=%h want 1 1 %h", i, imem_req_o, pc_stall_o, imem_addr_o, a0);
            end
            tick();
        end
        drive(1, 0, 1, 16'h0, 0);
        vectors++;
        if (pc_stall_o !== 1'b0) begin
            miscompares++; $display("FAIL gnt_fire_stall: stall=%b want 0", pc_stall_o);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        held = mem_word(m_raddr);
        drive(1, 0, 0, 16'h0, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 16'h0, 0);
            vectors++;
            if (imem_req_o !== 1'b0 || if_valid_o !== 1'b1 || if_instr_o !== held) begin
                miscompares++; $display("FAIL backpressure %0d: req=%b v=%b instr=%h want 0 1 %h", i, imem_req_o, if_valid_o, if_instr_o, held);
            end
            tick();
        end
        drive(1, 0, 1, 16'h0, 0);
        vectors++;
        if (imem_req_o !== 1'b1) begin
            miscompares++; $display("FAIL backpressure_release: req=%b want 1", imem_req_o);
        end
        tick();
        drive(0, 0, 1, 16'h0, 0);
        tick();
    endtask

    task automatic test_redirect_wait();
        logic [15:0] pd0;
        k_next = 3;
        drive(1, 0, 1, 16'h0, 0);
        tick();
        drive(0, 1, 1, 16'h0100, 0);
        vectors++;
        if (pc_stall_o !== 1'b0) begin
            miscompares++; $display("FAIL redir_wait_stall: stall=%b want 0", pc_stall_o);
        end
        tick();
        pd0 = exp_pd();
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 1, 16'h0, 0);
            vectors++;
            if (imem_req_o !== 1'b0 || if_valid_o !== 1'b0) begin
                miscompares++; $display("FAIL redir_drop %0d: req=%b v=%b want 0 0", i, imem_req_o, if_valid_o);
            end
            tick();
        end
        k_next = 1;
        drive(1, 0, 1, 16'h0, 0);
        vectors++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 16'h0100 || if_valid_o !== 1'b0) begin
            miscompares++; $display("FAIL redir_newpc: req=%b addr=%h v=%b want 1 0100 0", imem_req_o, imem_addr_o, if_valid_o);
        end
        vectors++;
`ifdef FETCH_CTRL_PERF_EN
        if (perf_drop_o !== pd0 + 16'd1) begin
            miscompares++; $display("FAIL redir_perf_drop: got %0d want %0d", perf_drop_o, pd0 + 16'd1);
        end
`else
        if (perf_drop_o !== 16'd0 || pd0 !== 16'd0) begin
            miscompares++; $display("FAIL redir_perf_drop: got %0d want 0", perf_drop_o);
        end
`endif
        tick();
        drive(0, 0, 1, 16'h0, 0);
        tick();
    endtask

    task automatic test_redirect_gnt();
        drive(1, 1, 1, 16'h0200, 0);
        vectors++;
        if (imem_req_o !== 1'b0 || pc_stall_o !== 1'b0) begin
            miscompares++; $display("FAIL redir_gnt: req=%b stall=%b want 0 0", imem_req_o, pc_stall_o);
        end
        tick();
        drive(0, 0, 1, 16'h0, 1);
        vectors++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 16'h0200 || if_valid_o !== 1'b0) begin
            miscompares++; $display("FAIL redir_gnt_next: req=%b addr=%h v=%b want 1 0200 0", imem_req_o, imem_addr_o, if_valid_o);
        end
        tick();
        drive(0, 0, 1, 16'h0, 0);
        vectors++;
        if (if_valid_o !== 1'b0 || imem_req_o !== 1'b1) begin
            miscompares++; $display("FAIL stray_rvalid: v=%b req=%b want 0 1", if_valid_o, imem_req_o);
        end
        tick();
    endtask

    task automatic test_timeout();
        k_next = 100000;
        drive(1, 0, 1, 16'h0, 0);
        tick();
        for (int w = 1; w <= 12; w++) begin
            drive(0, 0, 1, 16'h0, 0);
            vectors++;
            if (timeout_err_o !== 1'(w >= 9) || imem_req_o !== 1'b0) begin
                miscompares++; $display("FAIL timeout w=%0d: err=%b req=%b want err=%0d req=0", w, timeout_err_o, imem_req_o, w >= 9);
            end
            tick();
        end
        rst = 1'b1;
        drive(0, 0, 1, 16'h0, 0);
        tick();
        rst = 1'b0;
        drive(0, 0, 1, 16'h0, 0);
        vectors++;
        if (timeout_err_o !== 1'b0) begin
            miscompares++; $display("FAIL timeout_clear: err=%b want 0", timeout_err_o);
        end
        tick();
        k_next = 1;
    endtask

    task automatic test_reset_mid();
        k_next = 5;
        drive(1, 0, 1, 16'h0, 0);
        tick();
        drive(0, 0, 1, 16'h0, 0);
        tick();
        rst = 1'b1;
        drive(1, 0, 1, 16'h0, 0);
        vectors++;
        if (imem_req_o !== 1'b0 || pc_stall_o !== 1'b1) begin
            miscompares++; $display("FAIL rst_mid: req=%b stall=%b want 0 1", imem_req_o, pc_stall_o);
        end
        tick();
        rst = 1'b0;
        k_next = 1;
        drive(0, 0, 1, 16'h0, 1);
        vectors++;
        if (imem_req_o !== 1'b0 || if_valid_o !== 1'b0) begin
            miscompares++; $display("FAIL rst_mid_idle: req=%b v=%b want 0 0", imem_req_o, if_valid_o);
        end
        tick();
        drive(0, 0, 1, 16'h0, 1);
        tick();
        drive(0, 0, 1, 16'h0, 0);
        vectors++;
        if (imem_req_o !== 1'b1 || if_valid_o !== 1'b0) begin
            miscompares++; $display("FAIL rst_mid_stale: req=%b v=%b want 1 0", imem_req_o, if_valid_o);
        end
        tick();
    endtask

    task automatic test_random();
        bit g, rd, rdy, es;
        for (int i = 0; i < 1500; i++) begin
            g   = ($urandom_range(0, 3) != 0);
            rd  = ($urandom_range(0, 15) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            k_next = ($urandom_range(0, 49) == 0) ? 10 : int'($urandom_range(1, 4));
            drive(g, rd, rdy, 16'($urandom_range(0, 16'h3FFF) * 4), 0);
            es = !((m_exp_req && g) || rd);
            vectors++;
            if (imem_req_o !== m_exp_req || pc_stall_o !== es || (m_exp_req && imem_addr_o !== m_pc)) begin
                miscompares++; $display("FAIL rnd_req %0d: req=%b stall=%b addr=%h want %b %b %h", i, imem_req_o, pc_stall_o, imem_addr_o, m_exp_req, es, m_pc);
            end
            vectors++;
            if (if_valid_o !== m_slot_v || (m_slot_v && (if_pc_o !== m_slot_pc || if_instr_o !== m_slot_instr))) begin
                miscompares++; $display("FAIL rnd_slot %0d: v=%b pc=%h instr=%h want %b %h %h", i, if_valid_o, if_pc_o, if_instr_o, m_slot_v, m_slot_pc, m_slot_instr);
            end
            vectors++;
            if (timeout_err_o !== m_err || perf_fetch_o !== exp_pf() || perf_drop_o !== exp_pd()) begin
                miscompares++; $display("FAIL rnd_stat %0d: err=%b pf=%0d pd=%0d want %b %0d %0d", i, timeout_err_o, perf_fetch_o, perf_drop_o, m_err, exp_pf(), exp_pd());
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_gnt_stall();
        test_backpressure();
        test_redirect_wait();
        test_redirect_gnt();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
